shift_seq_ctrl: RTL and testbench

- Command sequencer that drives the mode, parallel and serial inputs of an ls74194 universal shift register.
- Accepts one command per valid/ready handshake: load, clear, shift or rotate by N positions.
- Issues the matching s/p/sil/sir pattern cycle by cycle, then pulses done.
- Sits directly upstream of ls74194 on the same clock; reads the register's q back for rotate fill and for the optional serial-out tap.

---
 rtl/shift_seq_ctrl.sv | 154 +++++++++++++++
 tb/tb_shift_seq_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_seq_ctrl.sv
// rtl/shift_seq_ctrl.sv - command sequencer driving the s/p/sil/sir inputs of an ls74194 shift register
// Optional serial-out tap (ser_out/ser_valid) is built when SHIFT_SEQ_SEROUT_EN is defined.
module shift_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int CW    = 3
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CW-1:0]    cmd_count,
  input  logic             cmd_fill,
  input  logic [WIDTH-1:0] q_fb,
`ifdef SHIFT_SEQ_SEROUT_EN
  output logic             ser_out,
  output logic             ser_valid,
`endif
  output logic [1:0]       s,
  output logic [WIDTH-1:0] p,
  output logic             sir,
  output logic             sil,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_SHR  = 3'b010;
  localparam logic [2:0] OP_SHL  = 3'b011;
  localparam logic [2:0] OP_ROR  = 3'b100;
  localparam logic [2:0] OP_ROL  = 3'b101;
  localparam logic [2:0] OP_CLR  = 3'b110;
  localparam logic [2:0] OP_RSVD = 3'b111;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_e;

  state_e           state_q;
  logic [1:0]       s_q;
  logic [WIDTH-1:0] p_q;
  logic             sir_q;
  logic             sil_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic             ready_q;
  logic [2:0]       op_q;
  logic [CW-1:0]    rem_q;

  logic is_shift_op;
  logic cmd_right;
  logic op_right;
  logic unused_q_fb;

  assign is_shift_op = (cmd_op >= OP_SHR) && (cmd_op <= OP_ROL);
  assign cmd_right   = (cmd_op == OP_SHR) || (cmd_op == OP_ROR);
  assign op_right    = (op_q == OP_SHR) || (op_q == OP_ROR);
  assign unused_q_fb = ^q_fb;

`ifdef SHIFT_SEQ_SEROUT_EN
  logic ser_out_q;
  logic ser_valid_q;
  assign ser_out   = ser_out_q;
  assign ser_valid = ser_valid_q;
`endif

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= IDLE;
      s_q     <= 2'b00;
      p_q     <= '0;
      sir_q   <= 1'b0;
      sil_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b1;
      op_q    <= 3'b000;
      rem_q   <= '0;
`ifdef SHIFT_SEQ_SEROUT_EN
      ser_out_q   <= 1'b0;
      ser_valid_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
`ifdef SHIFT_SEQ_SEROUT_EN
      ser_valid_q <= (state_q == SHIFT);
      if (state_q == SHIFT) begin
        ser_out_q <= op_right ? q_fb[0] : q_fb[WIDTH-1];
      end
`endif
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            if (cmd_op == OP_LOAD || cmd_op == OP_CLR) begin
              p_q     <= (cmd_op == OP_LOAD) ? cmd_data : '0;
              s_q     <= 2'b11;
              state_q <= LOAD;
            end else if (is_shift_op && cmd_count != '0) begin
              op_q    <= cmd_op;
              rem_q   <= cmd_count;
              s_q     <= cmd_right ? 2'b01 : 2'b10;
              sir_q   <= (cmd_op == OP_SHR) ? cmd_fill : 1'b0;
              sil_q   <= (cmd_op == OP_SHL) ? cmd_fill : 1'b0;
              state_q <= SHIFT;
            end else begin
              // NOP, zero-count shifts and the reserved opcode all complete immediately
              err_q   <= (cmd_op == OP_RSVD);
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        LOAD: begin
          s_q     <= 2'b00;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        SHIFT: begin
          rem_q <= rem_q - 1'b1;
          if (rem_q == CW'(1)) begin
            s_q     <= 2'b00;
            sir_q   <= 1'b0;
            sil_q   <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: begin
          s_q     <= 2'b00;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Rotate fill comes straight from the register so each edge sees the current end bit
  assign sir = (state_q == SHIFT && op_q == OP_ROR) ? q_fb[0]       : sir_q;
  assign sil = (state_q == SHIFT && op_q == OP_ROL) ? q_fb[WIDTH-1] : sil_q;

  assign s         = s_q;
  assign p         = p_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign cmd_ready = ready_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb/tb_shift_seq_ctrl.sv - bench for shift_seq_ctrl driving an ls74194 register model
module tb_shift_seq_ctrl;
  localparam int W  = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          clear_n = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_fill = 1'b0;
  logic [2:0]    cmd_op = 3'd0;
  logic [W-1:0]  cmd_data = '0;
  logic [CW-1:0] cmd_count = '0;
  logic          cmd_ready, sir, sil, busy, done, err;
  logic [1:0]    s;
  logic [W-1:0]  p;
  logic [W-1:0]  reg_q;
`ifdef SHIFT_SEQ_SEROUT_EN
  logic          ser_out, ser_valid;
`endif

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  shift_seq_ctrl #(.WIDTH(W), .CW(CW)) dut (
    .clk(clk), .clear_n(clear_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_count(cmd_count), .cmd_fill(cmd_fill),
    .q_fb(reg_q),
`ifdef SHIFT_SEQ_SEROUT_EN
    .ser_out(ser_out), .ser_valid(ser_valid),
`endif
    .s(s), .p(p), .sir(sir), .sil(sil), .busy(busy), .done(done), .err(err)
  );

  // ls74194 behaviour, sharing the clear
  always @(posedge clk or negedge clear_n) begin
    if (!clear_n) reg_q <= '0;
    else case (s)
      2'b01:   reg_q <= {sir, reg_q[W-1:1]};
      2'b10:   reg_q <= {reg_q[W-2:0], sil};
      2'b11:   reg_q <= p;
      default: reg_q <= reg_q;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle expectation; sel 0 = zero, 1 = latched fill, 2 = register end bit
  typedef struct packed {
    logic [1:0] s;
    logic       busy, done, err, ready;
    logic [1:0] sir_sel, sil_sel;
    logic       fill, chk_q;
    logic [3:0] q;
    logic       sv, sright;
  } exp_t;

  exp_t       expq[$];
  exp_t       cur;
  logic [3:0] model_q = '0;
  logic [3:0] prev_q = '0;

  function automatic exp_t idle_e();
    exp_t e;
    e = '0;
    e.ready = 1'b1;
    return e;
  endfunction

  task automatic model_accept(input logic [2:0] op, input logic [3:0] d, input logic [2:0] c, input logic f);
    exp_t e;
    e = '0;
    e.busy = 1'b1;
    if (op == 3'd1 || op == 3'd6) begin
      e.s = 2'b11;
      expq.push_back(e);
      model_q = (op == 3'd1) ? d : 4'd0;
    end else if (op >= 3'd2 && op <= 3'd5 && c != 0) begin
      e.s       = (op == 3'd2 || op == 3'd4) ? 2'b01 : 2'b10;
      e.sir_sel = (op == 3'd2) ? 2'd1 : (op == 3'd4) ? 2'd2 : 2'd0;
      e.sil_sel = (op == 3'd3) ? 2'd1 : (op == 3'd5) ? 2'd2 : 2'd0;
      e.fill    = f;
      e.sright  = (op == 3'd2 || op == 3'd4);
      for (int i = 0; i < int'(c); i++) begin
        e.sv = (i > 0);
        expq.push_back(e);
        case (op)
          3'd2:    model_q = {f, model_q[3:1]};
          3'd3:    model_q = {model_q[2:0], f};
          3'd4:    model_q = {model_q[0], model_q[3:1]};
          default: model_q = {model_q[2:0], model_q[3]};
        endcase
      end
      e.sv = 1'b1;
    end
    e.s = 2'b00; e.sir_sel = 2'd0; e.sil_sel = 2'd0;
    e.done  = 1'b1;
    e.err   = (op == 3'd7);
    e.chk_q = 1'b1;
    e.q     = model_q;
    expq.push_back(e);
  endtask

  always @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      expq.delete();
      cur = idle_e();
      model_q = '0;
    end else begin
      bit was_idle;
      was_idle = cur.ready;
      cur = (expq.size() > 0) ? expq.pop_front() : idle_e();
      if (was_idle && cmd_valid) begin
        model_accept(cmd_op, cmd_data, cmd_count, cmd_fill);
        cur = expq.pop_front();
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("s", 32'(s), 32'(cur.s));
      chk("busy", 32'(busy), 32'(cur.busy));
      chk("done", 32'(done), 32'(cur.done));
      chk("err", 32'(err), 32'(cur.err));
      chk("cmd_ready", 32'(cmd_ready), 32'(cur.ready));
      chk("sir", 32'(sir), 32'(cur.sir_sel == 2'd1 ? cur.fill : cur.sir_sel == 2'd2 ? reg_q[0] : 1'b0));
      chk("sil", 32'(sil), 32'(cur.sil_sel == 2'd1 ? cur.fill : cur.sil_sel == 2'd2 ? reg_q[3] : 1'b0));
      if (cur.chk_q) chk("q", 32'(reg_q), 32'(cur.q));
`ifdef SHIFT_SEQ_SEROUT_EN
      chk("ser_valid", 32'(ser_valid), 32'(cur.sv));
      if (cur.sv) chk("ser_out", 32'(ser_out), 32'(cur.sright ? prev_q[0] : prev_q[3]));
`endif
    end
    prev_q = reg_q;
  end

  task automatic send(input logic [2:0] op, input logic [3:0] d, input logic [2:0] c, input logic f);
    int g;
    @(negedge clk);
    cmd_op = op; cmd_data = d; cmd_count = c; cmd_fill = f; cmd_valid = 1'b1;
    g = 0;
    while (!cmd_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int n_s11, output int n_err,
                           output logic [3:0] sbits, output int nser);
    bit got;
    got = 1'b0; lat = 0; n_s11 = 0; n_err = 0; sbits = '0; nser = 0;
    for (int i = 1; i <= 40 && !got; i++) begin
      @(negedge clk);
      lat = i;
      if (s == 2'b11) n_s11++;
      if (err) n_err++;
`ifdef SHIFT_SEQ_SEROUT_EN
      if (ser_valid) begin
        if (nser < 4) sbits[nser[1:0]] = ser_out;
        nser++;
      end
`endif
      if (done) got = 1'b1;
    end
    if (!got) chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int lat, n11, nerr, nser, ndone;
    logic [3:0] sb;
    #1 clear_n = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_s", 32'(s), 32'd0);
    chk("rst_p", 32'(p), 32'd0);
    chk("rst_sir", 32'(sir), 32'd0);
    chk("rst_sil", 32'(sil), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    clear_n = 1'b1;
    chk_en = 1'b1;

    send(3'd1, 4'b1010, 3'd0, 1'b0);
    wait_done(lat, n11, nerr, sb, nser);
    chk("load_lat", 32'(lat), 32'd2);
    chk("load_s11", 32'(n11), 32'd1);
    chk("load_q", 32'(reg_q), 32'hA);
    @(negedge clk);
    chk("load_ready_back", 32'(cmd_ready), 32'd1);

    send(3'd2, 4'd0, 3'd1, 1'b0);
    wait_done(lat, n11, nerr, sb, nser);
    chk("shr1_lat", 32'(lat), 32'd2);
    chk("shr1_q", 32'(reg_q), 32'h5);
    send(3'd3, 4'd0, 3'd2, 1'b1);
    wait_done(lat, n11, nerr, sb, nser);
    chk("shl2_lat", 32'(lat), 32'd3);
    chk("shl2_q", 32'(reg_q), 32'h7);

    send(3'd1, 4'b1000, 3'd0, 1'b0);
    wait_done(lat, n11, nerr, sb, nser);
    send(3'd4, 4'd0, 3'd3, 1'b0);
    wait_done(lat, n11, nerr, sb, nser);
    chk("ror3_lat", 32'(lat), 32'd4);
    chk("ror3_q", 32'(reg_q), 32'h1);
    send(3'd5, 4'd0, 3'd4, 1'b0);
    wait_done(lat, n11, nerr, sb, nser);
    chk("rol4_lat", 32'(lat), 32'd5);
    chk("rol4_q", 32'(reg_q), 32'h1);

    send(3'd2, 4'd0, 3'd0, 1'b1);
    wait_done(lat, n11, nerr, sb, nser);
    chk("shr0_lat", 32'(lat), 32'd1);
    chk("shr0_err", 32'(nerr), 32'd0);
    send(3'd0, 4'd0, 3'd0, 1'b0);
    wait_done(lat, n11, nerr, sb, nser);
    chk("nop_lat", 32'(lat), 32'd1);
    chk("nop_err", 32'(nerr), 32'd0);
    send(3'd7, 4'd0, 3'd0, 1'b0);
    wait_done(lat, n11, nerr, sb, nser);
    chk("rsvd_lat", 32'(lat), 32'd1);
    chk("rsvd_err", 32'(nerr), 32'd1);

    // valid held across DONE: accepts only on every other edge
    repeat (2) @(negedge clk);
    cmd_op = 3'd0; cmd_valid = 1'b1;
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    cmd_valid = 1'b0;
    chk("held_valid_dones", 32'(ndone), 32'd3);
    repeat (3) @(negedge clk);

    send(3'd3, 4'd0, 3'd7, 1'b1);
    repeat (3) @(negedge clk);
    #2 clear_n = 1'b0;
    #1;
    chk("abort_s", 32'(s), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ready", 32'(cmd_ready), 32'd1);
    chk("abort_q", 32'(reg_q), 32'd0);
    @(negedge clk);
    #2 clear_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);

    send(3'd1, 4'b1101, 3'd0, 1'b0);
    wait_done(lat, n11, nerr, sb, nser);
    send(3'd2, 4'd0, 3'd4, 1'b0);
    wait_done(lat, n11, nerr, sb, nser);
    chk("serout_case_lat", 32'(lat), 32'd5);
    chk("serout_case_q", 32'(reg_q), 32'd0);
`ifdef SHIFT_SEQ_SEROUT_EN
    chk("ser_count", 32'(nser), 32'd4);
    chk("ser_bits", 32'(sb), 32'hD);
`endif

    for (int n = 0; n < 150; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
           3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    end
    repeat (20) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
